regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port register file; successor to the single-write, two-read 32x32 file.
//   Adds configurable width/depth/read-port count, a second write port, optional write-through
//   bypass, optional hardwired zero register, and a sequential clear engine run after reset or on request.
//   Sits in the decode stage of the MIPS datapath; feeds ALU operands and takes writeback results.
// PARAMETERS
//   DATA_W    32  register width in bits
//   ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//   NUM_RD    2   number of independent combinational read ports (1..4)
//   ZERO_REG  1   1: entry 0 always reads 0 and ignores writes
//   BYPASS    1   1: a read of an address written this cycle returns the write data
// PORTS
//   clk       in   1               clock; all state updates on posedge
//   rst       in   1               synchronous, active-high reset
//   rd_addr   in   NUM_RD*ADDR_W   read addresses; port i = bits [i*ADDR_W +: ADDR_W]
//   rd_data   out  NUM_RD*DATA_W   read data; port i = bits [i*DATA_W +: DATA_W]
//   wa_en     in   1               write port A enable
//   wa_addr   in   ADDR_W          write port A address
//   wa_data   in   DATA_W          write port A data
//   wb_en     in   1               write port B enable (priority port)
//   wb_addr   in   ADDR_W          write port B address
//   wb_data   in   DATA_W          write port B data
//   clr_req   in   1               single-cycle pulse: start a full clear sweep
//   busy      out  1               1 while the clear sweep runs
//   wr_drop   out  1               sticky: a write was dropped during busy; cleared by rst only
// BEHAVIOUR
//   FSM, two states: CLEAR, READY.
//   - rst=1 (any state): state<=CLEAR, clr_ptr<=0, busy<=1, wr_drop<=0. No entry is written that cycle.
//   - CLEAR: each cycle writes 0 to entry clr_ptr, clr_ptr<=clr_ptr+1. The cycle clr_ptr==DEPTH-1
//     is written moves the FSM to READY; busy=0 from the next cycle. busy is high for exactly
//     DEPTH cycles after rst is released.
//   - READY + clr_req=1: enter CLEAR with clr_ptr=0, busy<=1; any write in that same cycle is
//     still performed (it is overwritten by the sweep). clr_req during CLEAR is ignored; no restart.
//   - rst mid-sweep restarts the sweep from entry 0.
//   Writes (READY only): on posedge, wa_en writes wa_data to wa_addr, wb_en writes wb_data to wb_addr.
//     If both are enabled to the same address, port B wins and port A's write is discarded.
//     If ZERO_REG=1, writes to address 0 are ignored silently (no wr_drop).
//   Writes during CLEAR (or the rst cycle) are discarded; wa_en|wb_en in CLEAR sets wr_drop<=1.
//   Reads: combinational, zero latency, from current array contents.
//     - busy=1: every rd_data port returns 0.
//     - ZERO_REG=1 and rd_addr==0: 0 regardless of other rules.
//     - BYPASS=1, READY: if wb_en and wb_addr==rd_addr, return wb_data; else if wa_en and
//       wa_addr==rd_addr, return wa_data; else array value. Bypass matches write priority.
//     - BYPASS=0: array value; the new value is visible the cycle after the write edge.
//   Array contents are undefined only before the first reset; rd_data is 0 while busy.
//   Reset values: busy=1, wr_drop=0, rd_data=0 (while busy), state=CLEAR, clr_ptr=0.
//   Out-of-range addresses cannot occur (DEPTH = 2**ADDR_W); clr_ptr wraps naturally at DEPTH.
// TESTING
//   1 rst for 1 cycle, release -> busy=1 for exactly 32 cycles, then 0; all reads return 0 afterwards.
//   2 After clear: wa writes r5=0xDEADBEEF; same cycle rd_addr0=5 -> rd_data0=0xDEADBEEF (BYPASS=1);
//     next cycle still 0xDEADBEEF. With BYPASS=0 -> old value 0 that cycle, 0xDEADBEEF next.
//   3 wa (r7=0x11) and wb (r7=0x22) in the same cycle -> bypass read 0x22; array holds 0x22 afterwards.
//   4 Write r0=0xFFFFFFFF via both ports (ZERO_REG=1) -> rd on r0 returns 0, wr_drop stays 0.
//   5 clr_req with r3=0x1234 stored; wa write r4 during the sweep -> busy 32 cycles, wr_drop=1,
//     r3 and r4 read 0 after the sweep.
//   6 rst asserted at sweep cycle 10 -> sweep restarts; busy stays high 32 more cycles; wr_drop=0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file for the decode stage: NUM_RD combinational read ports, two write ports
// (B has priority), optional write-through bypass and hardwired zero entry, and a clear sweep engine.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wa_en,
    input  logic [ADDR_W-1:0]          wa_addr,
    input  logic [DATA_W-1:0]          wa_data,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       clr_req,
    output logic                       busy,
    output logic                       wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_ptr, clr_ptr_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                wa_fire, wb_fire;
    logic                byp_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        case (state)
            CLEAR: begin
                clr_ptr_nxt = ADDR_W'(clr_ptr + 1'b1);
                if (clr_ptr == {ADDR_W{1'b1}}) state_nxt = READY;
            end
            READY: begin
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_ptr_nxt = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign busy = (state == CLEAR);

    // Port A loses to port B on an address collision; entry 0 is write-protected when hardwired.
    assign wa_fire = !rst && (state == READY) && wa_en
                     && !((ZERO_REG != 0) && (wa_addr == '0))
                     && !(wb_en && (wb_addr == wa_addr));
    assign wb_fire = !rst && (state == READY) && wb_en
                     && !((ZERO_REG != 0) && (wb_addr == '0));

    always_ff @(posedge clk) begin
        if (!rst && (state == CLEAR)) begin
            mem[clr_ptr] <= '0;
        end else begin
            if (wa_fire) mem[wa_addr] <= wa_data;
            if (wb_fire) mem[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                  wr_drop <= 1'b0;
        else if ((state == CLEAR) && (wa_en || wb_en)) wr_drop <= 1'b1;
    end

    // Bypass only forwards writes that will actually land at the next edge.
    assign byp_ok = (BYPASS != 0) && !rst && (state == READY);

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rv = mem[ra];
            if (busy)
                rv = '0;
            else if ((ZERO_REG != 0) && (ra == '0))
                rv = '0;
            else if (byp_ok && wb_en && (wb_addr == ra))
                rv = wb_data;
            else if (byp_ok && wa_en && (wa_addr == ra))
                rv = wa_data;
        end

        assign rd_data[i*DATA_W +: DATA_W] = rv;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing instance and a non-bypassing instance share stimulus.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic [2*DW-1:0] rd_data_nb;
    logic          wa_en, wb_en, clr_req;
    logic [AW-1:0] wa_addr, wb_addr;
    logic [DW-1:0] wa_data, wb_data;
    logic          busy, busy_nb, wr_drop, wr_drop_nb;

    int errors = 0;
    int checks = 0;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .clr_req(clr_req), .busy(busy), .wr_drop(wr_drop)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .clr_req(clr_req), .busy(busy_nb), .wr_drop(wr_drop_nb)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wa_en = 0; wb_en = 0; clr_req = 0;
        wa_addr = '0; wb_addr = '0; wa_data = '0; wb_data = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        rd_addr = '0;
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++;
        if (busy !== 1'b1 || wr_drop !== 1'b0) begin
            errors++; $display("FAIL reset_state: busy=%b wr_drop=%b, expected busy=1 wr_drop=0", busy, wr_drop);
        end
        set_rd(5'd1, 5'd31);
        checks++;
        if (rd_data !== 64'h0) begin
            errors++; $display("FAIL reset_rd_zero: rd_data=%h expected 0", rd_data);
        end
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 32) begin
            errors++; $display("FAIL reset_busy_len: busy cycles=%0d expected 32", n);
        end
        for (int a = 0; a < 32; a += 2) begin
            set_rd(AW'(a), AW'(a + 1));
            checks++;
            if (rd_data !== 64'h0 || rd_data_nb !== 64'h0) begin
                errors++; $display("FAIL reset_cleared r%0d/r%0d: got %h / %h expected 0", a, a + 1, rd_data, rd_data_nb);
            end
        end
    endtask

    task automatic test_bypass();
        wa_en = 1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
        set_rd(5'd5, 5'd6);
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_same_cycle: got %h expected deadbeef", rd_data[31:0]);
        end
        checks++;
        if (rd_data_nb[31:0] !== 32'h0) begin
            errors++; $display("FAIL nobypass_same_cycle: got %h expected 0", rd_data_nb[31:0]);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF || rd_data_nb[31:0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_next_cycle: got %h / %h expected deadbeef", rd_data[31:0], rd_data_nb[31:0]);
        end
    endtask

    task automatic test_priority();
        wa_en = 1; wa_addr = 5'd7; wa_data = 32'h11;
        wb_en = 1; wb_addr = 5'd7; wb_data = 32'h22;
        set_rd(5'd7, 5'd5);
        checks++;
        if (rd_data !== {32'hDEADBEEF, 32'h22}) begin
            errors++; $display("FAIL priority_bypass: got %h expected deadbeef_00000022", rd_data);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h22 || rd_data_nb[31:0] !== 32'h22) begin
            errors++; $display("FAIL priority_array: got %h / %h expected 22", rd_data[31:0], rd_data_nb[31:0]);
        end
        // distinct addresses on both ports in one cycle
        wa_en = 1; wa_addr = 5'd10; wa_data = 32'hA0A0A0A0;
        wb_en = 1; wb_addr = 5'd11; wb_data = 32'hB1B1B1B1;
        set_rd(5'd10, 5'd11);
        checks++;
        if (rd_data !== {32'hB1B1B1B1, 32'hA0A0A0A0}) begin
            errors++; $display("FAIL dual_write_bypass: got %h expected b1b1b1b1_a0a0a0a0", rd_data);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd_data_nb !== {32'hB1B1B1B1, 32'hA0A0A0A0}) begin
            errors++; $display("FAIL dual_write_array: got %h expected b1b1b1b1_a0a0a0a0", rd_data_nb);
        end
    endtask

    task automatic test_zero_reg();
        wa_en = 1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
        wb_en = 1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        set_rd(5'd0, 5'd0);
        checks++;
        if (rd_data !== 64'h0) begin
            errors++; $display("FAIL zero_reg_bypass: got %h expected 0", rd_data);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd_data !== 64'h0 || rd_data_nb !== 64'h0 || wr_drop !== 1'b0) begin
            errors++; $display("FAIL zero_reg_after: rd=%h rd_nb=%h wr_drop=%b expected 0 0 0", rd_data, rd_data_nb, wr_drop);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [4];
        vals[0] = 32'h01020304; vals[1] = 32'h55AA55AA; vals[2] = 32'h80000001; vals[3] = 32'h7FFFFFFE;
        for (int k = 0; k < 4; k++) begin
            wa_en = 1; wa_addr = AW'(20 + k); wa_data = vals[k];
            set_rd(AW'(20 + k), AW'(20 + k - 1));
            checks++;
            if (k > 0 && (rd_data[63:32] !== vals[k-1] || rd_data_nb[63:32] !== vals[k-1])) begin
                errors++; $display("FAIL b2b_prev r%0d: got %h / %h expected %h", 19 + k, rd_data[63:32], rd_data_nb[63:32], vals[k-1]);
            end
            checks++;
            if (rd_data[31:0] !== vals[k]) begin
                errors++; $display("FAIL b2b_bypass r%0d: got %h expected %h", 20 + k, rd_data[31:0], vals[k]);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_clear_req();
        int n;
        wa_en = 1; wa_addr = 5'd3; wa_data = 32'h1234;
        tick();
        idle_inputs();
        set_rd(5'd3, 5'd4);
        checks++;
        if (rd_data[31:0] !== 32'h1234) begin
            errors++; $display("FAIL clr_pre_value: got %h expected 1234", rd_data[31:0]);
        end
        clr_req = 1;
        tick();
        clr_req = 0;
        #1;
        checks++;
        if (busy !== 1'b1 || rd_data !== 64'h0) begin
            errors++; $display("FAIL clr_start: busy=%b rd=%h expected busy=1 rd=0", busy, rd_data);
        end
        n = 0;
        while (busy && n < 100) begin
            wa_en   = (n == 0);
            wa_addr = 5'd4; wa_data = 32'h4444;
            clr_req = (n == 5);
            n++;
            tick();
        end
        idle_inputs();
        set_rd(5'd3, 5'd4);
        checks++;
        if (n !== 32) begin
            errors++; $display("FAIL clr_busy_len: busy cycles=%0d expected 32", n);
        end
        checks++;
        if (wr_drop !== 1'b1 || wr_drop_nb !== 1'b1) begin
            errors++; $display("FAIL clr_wr_drop: got %b / %b expected 1", wr_drop, wr_drop_nb);
        end
        checks++;
        if (rd_data !== 64'h0 || rd_data_nb !== 64'h0) begin
            errors++; $display("FAIL clr_r3_r4: got %h / %h expected 0", rd_data, rd_data_nb);
        end
        set_rd(5'd5, 5'd7);
        checks++;
        if (rd_data !== 64'h0) begin
            errors++; $display("FAIL clr_r5_r7: got %h expected 0", rd_data);
        end
    endtask

    task automatic test_rst_mid_sweep();
        int n;
        wb_en = 1; wb_addr = 5'd9; wb_data = 32'h9999;
        tick();
        idle_inputs();
        clr_req = 1;
        tick();
        clr_req = 0;
        for (int c = 0; c < 10; c++) tick();
        rst = 1;
        tick();
        rst = 0;
        #1;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 32) begin
            errors++; $display("FAIL rst_mid_busy_len: busy cycles=%0d expected 32", n);
        end
        checks++;
        if (wr_drop !== 1'b0) begin
            errors++; $display("FAIL rst_mid_wr_drop: got %b expected 0", wr_drop);
        end
        set_rd(5'd9, 5'd31);
        checks++;
        if (rd_data !== 64'h0) begin
            errors++; $display("FAIL rst_mid_cleared: got %h expected 0", rd_data);
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        rd_addr = '0;
        test_reset();
        test_bypass();
        test_priority();
        test_zero_reg();
        test_back_to_back();
        test_clear_req();
        test_rst_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
